// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks the destination registers of the instructions in the FWD_STAGES
// stages after decode (stage 0 = EX). For the instruction in decode it
// chooses forwarding sources, detects load-use hazards that need a stall,
// and produces the pipeline freeze, bubble and flush controls.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the 16-bit load-use
// stall counter. When it is undefined, stall_cnt is tied to zero and no
// counter flops exist. The port list is the same in both builds.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid                decode holds a real instruction
//   id_rs, id_rt            source register addresses
//   id_use_rs, id_use_rt    source is actually read
//   id_is_store             decode instruction is a store (rt = store data)
//   id_wr_en, id_wr_addr    decode instruction writes register id_wr_addr
//   id_is_load              decode instruction is a load
//   redirect                taken branch/jump resolved in decode
//   stall_ext               downstream freeze (memory busy)
//   perf_clr                synchronous clear of the stall counter
//   fwd_a, fwd_b            0 = regfile, k+1 = result of stage k
//   fwd_m                   late store-data forward from the load at mem
//   hold                    freeze PC and IF/ID register
//   bubble                  inject a NOP into EX
//   flush_id                clear IF/ID register
//   stall_cnt               load-use stall cycle count (saturating)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int AW         = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  localparam int SW        = $clog2(FWD_STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_is_store,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_wr_addr,
  input  logic          id_is_load,
  input  logic          redirect,
  input  logic          stall_ext,
  input  logic          perf_clr,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic          fwd_m,
  output logic          hold,
  output logic          bubble,
  output logic          flush_id,
  output logic [15:0]   stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic          is_load;
  } entry_t;

  entry_t sb_q [FWD_STAGES];
  entry_t id_rec;
  logic   hz_stall;

  // An entry supplies a source only when it really writes that (nonzero)
  // register and decode really reads it.
  function automatic logic src_hit(entry_t e, logic [AW-1:0] src, logic use_src);
    return e.valid && e.wr_en && (e.addr == src) && (src != '0) && use_src;
  endfunction

  assign id_rec = '{valid: 1'b1, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};

  // NOTE: every entry is reset, not just the valid bits, because a reset that
  // lands mid-stall must leave nothing that can match a source afterwards.
  // NOTE: sequential state uses non-blocking assignments so each entry takes
  // the pre-edge value of its predecessor regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FWD_STAGES; i++) sb_q[i] <= '0;
    end else if (!stall_ext) begin
      sb_q[0] <= (id_valid && !hz_stall) ? id_rec : '0;
      for (int i = 1; i < FWD_STAGES; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Forwarding and hazard resolution. Scanning from the oldest stage down to
  // stage 0 leaves the youngest (lowest-index) match as the winner; older
  // matches are simply overwritten, so there is no fall-through.
  logic a_hit, a_load, b_hit, b_load, stall_a, stall_b;
  int   a_idx, b_idx;

  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    a_hit   = 1'b0;
    a_load  = 1'b0;
    a_idx   = 0;
    b_hit   = 1'b0;
    b_load  = 1'b0;
    b_idx   = 0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    fwd_a   = '0;
    fwd_b   = '0;
    fwd_m   = 1'b0;

    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (src_hit(sb_q[i], id_rs, id_use_rs)) begin
        a_hit  = 1'b1;
        a_load = sb_q[i].is_load;
        a_idx  = i;
      end
      if (src_hit(sb_q[i], id_rt, id_use_rt)) begin
        b_hit  = 1'b1;
        b_load = sb_q[i].is_load;
        b_idx  = i;
      end
    end

    if (a_hit) begin
      if (a_load && a_idx < LOAD_LAT) stall_a = 1'b1;
      else                            fwd_a   = SW'(a_idx + 1);
    end

    if (b_hit) begin
      if (b_load && b_idx < LOAD_LAT) begin
        // Store data is needed only at mem, so a load exactly one stage short
        // of forwardable can still feed it through the late mem-stage path.
        if (id_is_store && b_idx == LOAD_LAT - 1) fwd_m   = 1'b1;
        else                                      stall_b = 1'b1;
      end else begin
        fwd_b = SW'(b_idx + 1);
      end
    end

    hz_stall = stall_a | stall_b;
  end

  assign hold     = hz_stall | stall_ext;
  assign bubble   = hz_stall & ~stall_ext;
  // A redirect seen while frozen is dropped; decode re-asserts it once the
  // hold clears.
  assign flush_id = redirect & ~hold;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
    end else if (bubble && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard at its defaults (AW=5, FWD_STAGES=2,
// LOAD_LAT=1). Inputs change on the falling edge and outputs are sampled
// shortly after, well away from the rising edge the DUT registers on.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       id_use_rs, id_use_rt, id_is_store, id_wr_en, id_is_load;
  logic       redirect, stall_ext, perf_clr;
  logic [1:0] fwd_a, fwd_b;
  logic       fwd_m, hold, bubble, flush_id;
  logic [15:0] stall_cnt;

  int checks = 0;
  int passed = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [15:0] CNT_ONE   = 16'd1;
  localparam logic [15:0] CNT_THREE = 16'd3;
`else
  localparam logic [15:0] CNT_ONE   = 16'd0;
  localparam logic [15:0] CNT_THREE = 16'd0;
`endif

  hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_is_store(id_is_store),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .redirect   (redirect),
    .stall_ext  (stall_ext),
    .perf_clr   (perf_clr),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .fwd_m      (fwd_m),
    .hold       (hold),
    .bubble     (bubble),
    .flush_id   (flush_id),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one decode record and let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic st,
                       input logic we, input logic [4:0] wa, input logic ld);
    id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
    id_is_store = st;  id_wr_en = we;  id_wr_addr = wa;  id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic issue_alu(input logic [4:0] wa);
    drive(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, wa, 1'b0);
  endtask

  task automatic issue_load(input logic [4:0] wa);
    drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, wa, 1'b1);
  endtask

  task automatic flush_pipe();
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({fwd_a, fwd_b, fwd_m, hold, bubble, flush_id} !== 8'b0) $display("FAIL reset_outputs: got %b expected %b", {fwd_a, fwd_b, fwd_m, hold, bubble, flush_id}, 8'b0);
    else passed++;
    stall_ext = 1'b1; redirect = 1'b1; #1;
    checks++;
    if ({hold, bubble, flush_id} !== 3'b100) $display("FAIL reset_stall_ext: hold/bubble/flush got %b expected 100", {hold, bubble, flush_id});
    else passed++;
    stall_ext = 1'b0; #1;
    checks++;
    if ({hold, flush_id} !== 2'b01) $display("FAIL reset_redirect: hold/flush got %b expected 01", {hold, flush_id});
    else passed++;
    redirect = 1'b0;
    rst_n = 1'b1;
    tick();
    // Create a load-use stall, then reset in the middle of it.
    issue_load(5'd3);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
    checks++;
    if ({hold, bubble} !== 2'b11) $display("FAIL reset_pre_stall: hold/bubble got %b expected 11", {hold, bubble});
    else passed++;
    rst_n = 1'b0; #1;
    checks++;
    if ({fwd_a, hold, bubble} !== 4'b0000) $display("FAIL reset_mid_stall: fwd_a/hold/bubble got %b expected 0000", {fwd_a, hold, bubble});
    else passed++;
    rst_n = 1'b1; #1;
    checks++;
    if ({fwd_a, hold} !== 3'b000) $display("FAIL reset_after_release: fwd_a/hold got %b expected 000", {fwd_a, hold});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    flush_pipe();
  endtask

  task automatic test_alu_dep();
    issue_alu(5'd5);
    checks++;
    if (fwd_a !== 2'd0) $display("FAIL alu_no_dep: fwd_a got %0d expected 0", fwd_a);
    else passed++;
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({fwd_a, hold} !== 3'b010) $display("FAIL alu_fwd_ex: fwd_a/hold got %b expected 010", {fwd_a, hold});
    else passed++;
    flush_pipe();
    issue_alu(5'd5);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) $display("FAIL alu_fwd_gap: fwd_a/fwd_b got %b expected 1010", {fwd_a, fwd_b});
    else passed++;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1000) $display("FAIL alu_use_rt_off: fwd_a/fwd_b got %b expected 1000", {fwd_a, fwd_b});
    else passed++;
    flush_pipe();
    issue_alu(5'd0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL alu_r0: fwd_a/fwd_b got %b expected 0000", {fwd_a, fwd_b});
    else passed++;
    flush_pipe();
    issue_alu(5'd6);
    tick();
    issue_alu(5'd6);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (fwd_a !== 2'd1) $display("FAIL alu_youngest_wins: fwd_a got %0d expected 1", fwd_a);
    else passed++;
    flush_pipe();
    issue_alu(5'd9);
    tick();
    drive(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (fwd_a !== 2'd2) $display("FAIL alu_skip_nowrite: fwd_a got %0d expected 2", fwd_a);
    else passed++;
    flush_pipe();
  endtask

  task automatic test_load_use();
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    checks++;
    if ({hold, bubble, fwd_b} !== 4'b1100) $display("FAIL load_use_stall: hold/bubble/fwd_b got %b expected 1100", {hold, bubble, fwd_b});
    else passed++;
    tick();
    checks++;
    if ({hold, bubble, fwd_b} !== 4'b0010) $display("FAIL load_use_release: hold/bubble/fwd_b got %b expected 0010", {hold, bubble, fwd_b});
    else passed++;
    flush_pipe();
  endtask

  task automatic test_store();
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({fwd_m, fwd_b, hold, bubble} !== 5'b10000) $display("FAIL store_data_fwd_m: fwd_m/fwd_b/hold/bubble got %b expected 10000", {fwd_m, fwd_b, hold, bubble});
    else passed++;
    flush_pipe();
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({hold, fwd_a, fwd_m} !== 4'b1000) $display("FAIL store_addr_stall: hold/fwd_a/fwd_m got %b expected 1000", {hold, fwd_a, fwd_m});
    else passed++;
    tick();
    checks++;
    if ({hold, fwd_a} !== 3'b010) $display("FAIL store_addr_release: hold/fwd_a got %b expected 010", {hold, fwd_a});
    else passed++;
    flush_pipe();
  endtask

  task automatic test_redirect_stall_ext();
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    redirect = 1'b1; #1;
    checks++;
    if ({hold, flush_id} !== 2'b10) $display("FAIL redirect_stalled: hold/flush got %b expected 10", {hold, flush_id});
    else passed++;
    tick();
    checks++;
    if ({hold, flush_id} !== 2'b01) $display("FAIL redirect_honoured: hold/flush got %b expected 01", {hold, flush_id});
    else passed++;
    redirect = 1'b0;
    flush_pipe();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    issue_alu(5'd5);
    tick();
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    stall_ext = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fwd_a, fwd_b, hold, bubble} !== 6'b100010) $display("FAIL stall_ext_frozen_%0d: fwd_a/fwd_b/hold/bubble got %b expected 100010", i, {fwd_a, fwd_b, hold, bubble});
      else passed++;
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL stall_ext_cnt: got %0d expected 0", stall_cnt);
    else passed++;
    stall_ext = 1'b0; #1;
    checks++;
    if ({hold, bubble} !== 2'b11) $display("FAIL stall_ext_drop: hold/bubble got %b expected 11", {hold, bubble});
    else passed++;
    tick();
    checks++;
    if ({fwd_a, fwd_b, hold} !== 5'b00100) $display("FAIL stall_ext_resume: fwd_a/fwd_b/hold got %b expected 00100", {fwd_a, fwd_b, hold});
    else passed++;
    checks++;
    if (stall_cnt !== CNT_ONE) $display("FAIL stall_ext_cnt_after: got %0d expected %0d", stall_cnt, CNT_ONE);
    else passed++;
    flush_pipe();
  endtask

  task automatic test_counter();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_load(5'd7);
      tick();
      drive(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
      tick();
      idle();
      tick();
    end
    checks++;
    if (stall_cnt !== CNT_THREE) $display("FAIL cnt_three: got %0d expected %0d", stall_cnt, CNT_THREE);
    else passed++;
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    idle();
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL cnt_clr_priority: got %0d expected 0", stall_cnt);
    else passed++;
`ifdef HAZARD_PERF_CNT_EN
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    issue_load(5'd7);
    tick();
    drive(1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    tick();
    idle();
    checks++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL cnt_saturate: got %h expected ffff", stall_cnt);
    else passed++;
`endif
    flush_pipe();
  endtask

  initial begin
    rst_n     = 1'b0;
    redirect  = 1'b0;
    stall_ext = 1'b0;
    perf_clr  = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_is_store = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0;
    test_reset();
    test_alu_dep();
    test_load_use();
    test_store();
    test_redirect_stall_ext();
    test_counter();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
